mem_stage: RTL



---
 rtl/mem_stage.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage of the RV32I five-stage pipeline.
//
// Consumes the execute-stage bus, performs loads and stores on a
// request/grant/response data-memory port and hands the memory-stage bus to
// writeback through a single-entry registered valid/ready output.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   e_valid_i/e_ready_o/e_bus_i : execute-stage handshake and payload
//   m_valid_o/m_ready_i/m_bus_o : writeback handshake and registered payload
//   dmem_req_o/we_o/addr_o/wdata_o : data-memory request (held until grant)
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i : grant and read response
//   misalign_o        : one-cycle pulse when a misaligned access is dropped
//
// State | meaning
//   IDLE | ready for a new instruction
//   REQ  | request on the bus, waiting for grant
//   WAIT | load granted, waiting for read data

package utils_pkg;
  typedef struct packed {
    logic [31:0] ex_out;
    logic [31:0] rf_rdata2;
    logic [31:0] inc_pc;
    logic [3:0]  dmem_wr_en;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        rf_wr_en;
    logic        sel_res;
    logic        sel_rf_wr;
    logic        ecall;
  } bus_stage_e;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] inc_pc;
    logic [4:0]  rd;
    logic        rf_wr_en;
    logic        sel_rf_wr;
    logic        ecall;
  } bus_stage_m;
endpackage

module mem_stage
  import utils_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid_i,
  output logic        e_ready_o,
  input  bus_stage_e  e_bus_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output bus_stage_m  m_bus_o,
  output logic        dmem_req_o,
  output logic [3:0]  dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q;
  logic        m_valid_q;
  bus_stage_m  m_bus_q;
  logic        dmem_req_q;
  logic [3:0]  dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic        misalign_q;

  // Latched memory instruction: its writeback payload (result = ex_out),
  // load width/sign and whether it is a store.
  bus_stage_m  lat_m_q;
  logic [2:0]  lat_funct3_q;
  logic        lat_store_q;

  logic        e_store;
  logic        e_load;
  logic        e_mem;
  logic [1:0]  e_off;
  logic        e_half;
  logic        e_word;
  logic        e_mis;
  logic        accept;
  logic        start_mem;
  bus_stage_m  e_pass;

  logic [1:0]  lat_off;
  logic [31:0] rdata_sh;
  logic [31:0] load_data;

  logic        m_wr;
  bus_stage_m  m_bus_d;

  // Instruction classification on the incoming payload.
  assign e_store = |e_bus_i.dmem_wr_en;
  assign e_load  = !e_store && e_bus_i.sel_res;
  assign e_mem   = e_store || e_load;
  assign e_off   = e_bus_i.ex_out[1:0];

  // Access size comes from the byte-enable pattern for stores and from
  // funct3 for loads.
  assign e_half = e_store ? (e_bus_i.dmem_wr_en == 4'b0011)
                          : (e_bus_i.funct3[1:0] == 2'b01);
  assign e_word = e_store ? (e_bus_i.dmem_wr_en == 4'b1111)
                          : (e_bus_i.funct3[1:0] == 2'b10);
  assign e_mis  = e_mem && ((e_half && (e_off == 2'd3)) ||
                            (e_word && (e_off != 2'd0)));

  assign e_ready_o = (state_q == IDLE) && (!m_valid_q || m_ready_i);
  assign accept    = e_valid_i && e_ready_o;
  assign start_mem = accept && e_mem && !e_mis;

  // Pass-through payload; a dropped misaligned access writes nothing back.
  always_comb begin
    e_pass           = '0;
    e_pass.result    = e_bus_i.ex_out;
    e_pass.inc_pc    = e_bus_i.inc_pc;
    e_pass.rd        = e_bus_i.rd;
    e_pass.rf_wr_en  = e_bus_i.rf_wr_en;
    e_pass.sel_rf_wr = e_bus_i.sel_rf_wr;
    e_pass.ecall     = e_bus_i.ecall;
    if (e_mis) begin
      e_pass.result   = '0;
      e_pass.rf_wr_en = 1'b0;
    end
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  assign lat_off  = lat_m_q.result[1:0];
  assign rdata_sh = dmem_rdata_i >> {lat_off, 3'b000};

  always_comb begin
    load_data = '0;
    case (lat_funct3_q)
      3'b000:  load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  load_data = {24'd0, rdata_sh[7:0]};
      3'b001:  load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  load_data = {16'd0, rdata_sh[15:0]};
      3'b010:  load_data = dmem_rdata_i;
      default: load_data = '0;
    endcase
  end

  // Output register write selection. A write is only possible while the
  // output entry is empty or draining: acceptance requires that, and no
  // other write can reach it until the memory instruction completes.
  always_comb begin
    m_wr    = 1'b0;
    m_bus_d = lat_m_q;
    case (state_q)
      IDLE: begin
        if (accept && !start_mem) begin
          m_wr    = 1'b1;
          m_bus_d = e_pass;
        end
      end
      REQ: begin
        if (dmem_gnt_i && lat_store_q) m_wr = 1'b1;
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          m_wr           = 1'b1;
          m_bus_d.result = load_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      m_valid_q    <= 1'b0;
      m_bus_q      <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      misalign_q   <= 1'b0;
      lat_m_q      <= '0;
      lat_funct3_q <= '0;
      lat_store_q  <= 1'b0;
    end else begin
      misalign_q <= accept && e_mis;

      if (m_wr) begin
        m_valid_q <= 1'b1;
        m_bus_q   <= m_bus_d;
      end else if (m_valid_q && m_ready_i) begin
        m_valid_q <= 1'b0;
        m_bus_q   <= '0;
      end

      case (state_q)
        IDLE: begin
          if (start_mem) begin
            state_q      <= REQ;
            dmem_req_q   <= 1'b1;
            lat_m_q      <= e_pass;
            lat_funct3_q <= e_bus_i.funct3;
            lat_store_q  <= e_store;
            dmem_addr_q  <= {e_bus_i.ex_out[31:2], 2'b00};
            dmem_we_q    <= e_store ? (e_bus_i.dmem_wr_en << e_off) : 4'd0;
            dmem_wdata_q <= e_store ? (e_bus_i.rf_rdata2 << {e_off, 3'b000})
                                    : 32'd0;
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            state_q    <= lat_store_q ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          dmem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid_o    = m_valid_q;
  assign m_bus_o      = m_bus_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign misalign_o   = misalign_q;

endmodule
